// File: rtl/bus_timer_responder.sv
// APB-like responder hosting a 64-bit machine timer (mtime/mtimecmp, control, prescaler)
// with a fixed number of wait states before each transfer completes.
module bus_timer_responder #(
    parameter int unsigned WaitCycles         = 0,
    parameter bit          CounterResetEnable = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        select,
    input  logic        enable,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        irqTimer,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WaitCycles);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_wait_cnt;
    logic [2:0]  r_off;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_count_en;
    logic        r_irq_en;
    logic [15:0] r_prescale;
    logic [15:0] r_pcnt;
    logic        r_irq;

    logic        w_start;
    logic        w_commit;
    logic [2:0]  w_off;
    logic        w_write;
    logic [31:0] w_wdata;
    logic [31:0] w_rd_val;
    logic        w_unused_addr;

    // Handshake: a transfer starts when select&&enable is seen in IDLE; ready is a
    // single-cycle pulse, and rdata carries read data only while ready is high.
    assign w_start       = (r_state == ST_IDLE) && select && enable;
    assign w_off         = w_start ? addr[4:2] : r_off;
    assign w_write       = w_start ? write : r_write;
    assign w_wdata       = w_start ? wdata : r_wdata;
    assign w_commit      = (w_next_state == ST_RESP) && (r_state != ST_RESP);
    assign w_unused_addr = ^{addr[31:5], addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_off      <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_wait_cnt <= WAIT_INIT;
                r_off      <= addr[4:2];
                r_write    <= write;
                r_wdata    <= wdata;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rdata <= w_write ? 32'd0 : w_rd_val;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (select && enable) begin
                    w_next_state = (WaitCycles == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!select) begin
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt == 4'd1) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = (r_state == ST_RESP);
        rdata     = (r_state == ST_RESP) ? r_rdata : 32'd0;
        irqTimer  = r_irq;
        dbg_state = r_state;
    end

    always_comb begin
        w_rd_val = 32'd0;
        case (w_off)
            3'd0: w_rd_val = r_mtime[31:0];
            3'd1: w_rd_val = r_mtime[63:32];
            3'd2: w_rd_val = r_mtimecmp[31:0];
            3'd3: w_rd_val = r_mtimecmp[63:32];
            3'd4: w_rd_val = {30'd0, r_irq_en, r_count_en};
            3'd5: w_rd_val = {16'd0, r_prescale};
            default: w_rd_val = 32'd0;
        endcase
    end

    // Bus writes are placed after the increment so a write to either mtime half
    // replaces the whole incremented value for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_count_en <= CounterResetEnable;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (r_count_en) begin
                if (r_pcnt == r_prescale) begin
                    r_pcnt  <= '0;
                    r_mtime <= r_mtime + 64'd1;
                end else begin
                    r_pcnt <= r_pcnt + 16'd1;
                end
            end
            if (w_commit && w_write) begin
                case (w_off)
                    3'd0: r_mtime <= {r_mtime[63:32], w_wdata};
                    3'd1: r_mtime <= {w_wdata, r_mtime[31:0]};
                    3'd2: r_mtimecmp[31:0] <= w_wdata;
                    3'd3: r_mtimecmp[63:32] <= w_wdata;
                    3'd4: begin
                        r_count_en <= w_wdata[0];
                        r_irq_en   <= w_wdata[1];
                    end
                    3'd5: begin
                        r_prescale <= w_wdata[15:0];
                        r_pcnt     <= '0;
                    end
                    default: ;
                endcase
            end
            r_irq <= r_irq_en && (r_mtime >= r_mtimecmp);
        end
    end
endmodule

// File: tb/tb_bus_timer_responder.sv
// Bench for bus_timer_responder: three instances (0, 3 and 4 wait states) driven by
// directed and random transfers, checked against a cycle-level timer model.
module tb_bus_timer_responder;
    logic        clk;
    logic        rst;
    logic        sel_i   [3];
    logic        en_i    [3];
    logic        wr_i    [3];
    logic [31:0] addr_i  [3];
    logic [31:0] wdata_i [3];
    logic [31:0] rdata_o [3];
    logic        ready_o [3];
    logic        irq_o   [3];
    logic [1:0]  dbg_o   [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference timer state, one entry per instance.
    logic [63:0] m_mtime  [3];
    logic [63:0] m_cmp    [3];
    logic [15:0] m_pre    [3];
    logic [15:0] m_pcnt   [3];
    logic        m_cnt_en [3];
    logic        m_irq_en [3];
    logic        m_irq    [3];
    logic        c_pend   [3];
    logic [2:0]  c_off    [3];
    logic        c_wr     [3];
    logic [31:0] c_wd     [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bus_timer_responder #(
            .WaitCycles        (g == 0 ? 0 : (g == 1 ? 3 : 4)),
            .CounterResetEnable(g == 2 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .addr     (addr_i[g]),
            .select   (sel_i[g]),
            .enable   (en_i[g]),
            .write    (wr_i[g]),
            .wdata    (wdata_i[g]),
            .rdata    (rdata_o[g]),
            .ready    (ready_o[g]),
            .irqTimer (irq_o[g]),
            .dbg_state(dbg_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic logic cre(input int k);
        return (k == 2) ? 1'b0 : 1'b1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int k, input logic [2:0] off);
        case (off)
            3'd0: return m_mtime[k][31:0];
            3'd1: return m_mtime[k][63:32];
            3'd2: return m_cmp[k][31:0];
            3'd3: return m_cmp[k][63:32];
            3'd4: return {30'd0, m_irq_en[k], m_cnt_en[k]};
            3'd5: return {16'd0, m_pre[k]};
            default: return 32'd0;
        endcase
    endfunction

    // Advance one instance's timer by one clock from this cycle's inputs.
    task automatic model_step(input int k);
        logic [63:0] nt;
        logic [15:0] np;
        logic        wm;
        if (rst) begin
            m_mtime[k]  = 64'd0;
            m_cmp[k]    = '1;
            m_cnt_en[k] = cre(k);
            m_irq_en[k] = 1'b0;
            m_pre[k]    = 16'd0;
            m_pcnt[k]   = 16'd0;
            m_irq[k]    = 1'b0;
            c_pend[k]   = 1'b0;
            return;
        end
        nt = m_mtime[k];
        np = m_pcnt[k];
        wm = c_pend[k] && c_wr[k] && (c_off[k] <= 3'd1);
        if (m_cnt_en[k]) begin
            if (m_pcnt[k] == m_pre[k]) begin
                np = 16'd0;
                if (!wm) nt = m_mtime[k] + 64'd1;
            end else begin
                np = m_pcnt[k] + 16'd1;
            end
        end
        m_irq[k] = m_irq_en[k] && (m_mtime[k] >= m_cmp[k]);
        if (c_pend[k] && c_wr[k]) begin
            case (c_off[k])
                3'd0: nt[31:0] = c_wd[k];
                3'd1: nt[63:32] = c_wd[k];
                3'd2: m_cmp[k][31:0] = c_wd[k];
                3'd3: m_cmp[k][63:32] = c_wd[k];
                3'd4: begin
                    m_cnt_en[k] = c_wd[k][0];
                    m_irq_en[k] = c_wd[k][1];
                end
                3'd5: begin
                    m_pre[k] = c_wd[k][15:0];
                    np = 16'd0;
                end
                default: ;
            endcase
        end
        m_mtime[k] = nt;
        m_pcnt[k]  = np;
        c_pend[k]  = 1'b0;
    endtask

    task automatic tick();
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check($sformatf("irq%0d", k), 64'(irq_o[k]), 64'(m_irq[k]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_setup(input int k, input logic [2:0] off, input logic w, input logic [31:0] d);
        logic [31:0] a;
        a       = $urandom;
        a[4:2]  = off;
        sel_i[k]   = 1'b1;
        en_i[k]    = 1'b0;
        addr_i[k]  = a;
        wr_i[k]    = w;
        wdata_i[k] = d;
    endtask

    task automatic xfer(input int k, input logic [2:0] off, input logic w, input logic [31:0] d);
        logic [31:0] exp_rd;
        exp_rd = 32'd0;
        drive_setup(k, off, w, d);
        tick();
        en_i[k] = 1'b1;
        for (int i = 0; i <= wc(k); i++) begin
            if (i > 0) begin
                addr_i[k]  = $urandom;
                wdata_i[k] = $urandom;
                wr_i[k]    = 1'($urandom_range(0, 1));
            end
            check($sformatf("ready_low%0d", k), 64'(ready_o[k]), 64'd0);
            if (i == wc(k)) begin
                exp_rd    = model_read(k, off);
                c_pend[k] = 1'b1;
                c_off[k]  = off;
                c_wr[k]   = w;
                c_wd[k]   = d;
            end
            tick();
        end
        check($sformatf("ready_resp%0d", k), 64'(ready_o[k]), 64'd1);
        if (!w) check($sformatf("rdata%0d_off%0d", k, off), 64'(rdata_o[k]), 64'(exp_rd));
        sel_i[k] = 1'b0;
        en_i[k]  = 1'b0;
        tick();
        check($sformatf("ready_after%0d", k), 64'(ready_o[k]), 64'd0);
        check($sformatf("rdata_after%0d", k), 64'(rdata_o[k]), 64'd0);
    endtask

    // Start a write, then abort it in WAIT by dropping select or by reset.
    task automatic xfer_abort(input int k, input logic [2:0] off, input logic [31:0] d,
                              input int drop_at, input logic use_rst);
        drive_setup(k, off, 1'b1, d);
        tick();
        en_i[k] = 1'b1;
        tick();
        for (int i = 1; i < drop_at; i++) begin
            check("abort_wait_ready", 64'(ready_o[k]), 64'd0);
            tick();
        end
        if (use_rst) begin
            rst = 1'b1;
        end else begin
            sel_i[k] = 1'b0;
            en_i[k]  = 1'b0;
        end
        check("abort_drop_ready", 64'(ready_o[k]), 64'd0);
        tick();
        rst      = 1'b0;
        sel_i[k] = 1'b0;
        en_i[k]  = 1'b0;
        for (int i = 0; i <= wc(k); i++) begin
            check("abort_no_ready", 64'(ready_o[k]), 64'd0);
            check("abort_rdata", 64'(rdata_o[k]), 64'd0);
            tick();
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ready%0d", k), 64'(ready_o[k]), 64'd0);
            check($sformatf("rst_rdata%0d", k), 64'(rdata_o[k]), 64'd0);
            check($sformatf("rst_irq%0d", k), 64'(irq_o[k]), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sel_i[k] = 1'b0; en_i[k] = 1'b0; wr_i[k] = 1'b0;
            addr_i[k] = 32'd0; wdata_i[k] = 32'd0; c_pend[k] = 1'b0;
        end
        #1;
        idle(2);
        rst = 1'b0;
        check_reset_outputs();

        // Zero wait states: back-to-back reads of a free-running mtime.
        xfer(0, 3'd0, 1'b0, 32'd0);
        xfer(0, 3'd0, 1'b0, 32'd0);
        xfer(0, 3'd4, 1'b0, 32'd0);
        xfer(0, 3'd1, 1'b0, 32'd0);

        // Three wait states: stop the counter, load mtime, read it back.
        xfer(1, 3'd4, 1'b1, 32'd0);
        xfer(1, 3'd0, 1'b1, 32'h0000_0010);
        xfer(1, 3'd0, 1'b0, 32'd0);
        xfer(1, 3'd1, 1'b0, 32'd0);
        idle(3);
        xfer(1, 3'd0, 1'b0, 32'd0);

        // Prescaled counting.
        xfer(0, 3'd4, 1'b1, 32'd1);
        xfer(0, 3'd0, 1'b1, 32'd0);
        xfer(0, 3'd1, 1'b1, 32'd0);
        xfer(0, 3'd5, 1'b1, 32'd3);
        idle($urandom_range(15, 25));
        xfer(0, 3'd0, 1'b0, 32'd0);
        xfer(0, 3'd5, 1'b0, 32'd0);

        // Compare match raises irq; raising mtimecmp clears it.
        xfer(0, 3'd4, 1'b1, 32'd0);
        xfer(0, 3'd5, 1'b1, 32'd0);
        xfer(0, 3'd2, 1'b1, 32'd100);
        xfer(0, 3'd3, 1'b1, 32'd0);
        xfer(0, 3'd0, 1'b1, 32'd95);
        xfer(0, 3'd1, 1'b1, 32'd0);
        xfer(0, 3'd4, 1'b1, 32'd3);
        idle(8);
        check("irq_match", 64'(irq_o[0]), 64'd1);
        xfer(0, 3'd2, 1'b1, 32'hFFFF_FFFF);
        xfer(0, 3'd3, 1'b1, 32'hFFFF_FFFF);
        idle(2);
        check("irq_cleared", 64'(irq_o[0]), 64'd0);

        // 64-bit wrap and write/increment collisions.
        xfer(0, 3'd4, 1'b1, 32'd0);
        xfer(0, 3'd0, 1'b1, 32'hFFFF_FFFE);
        xfer(0, 3'd1, 1'b1, 32'hFFFF_FFFF);
        xfer(0, 3'd4, 1'b1, 32'd1);
        xfer(0, 3'd0, 1'b0, 32'd0);
        xfer(0, 3'd1, 1'b0, 32'd0);
        v = $urandom;
        xfer(0, 3'd1, 1'b1, v);
        xfer(0, 3'd4, 1'b1, 32'd0);
        xfer(0, 3'd0, 1'b0, 32'd0);
        xfer(0, 3'd1, 1'b0, 32'd0);
        xfer(0, 3'd4, 1'b1, 32'd1);
        xfer(0, 3'd0, 1'b1, $urandom);
        xfer(0, 3'd1, 1'b0, 32'd0);
        xfer(0, 3'd0, 1'b0, 32'd0);

        // Four wait states: abort by select drop, abort by reset, unmapped offsets.
        v = $urandom;
        xfer(2, 3'd0, 1'b1, v);
        xfer_abort(2, 3'd0, ~v, $urandom_range(1, 4), 1'b0);
        xfer(2, 3'd0, 1'b0, 32'd0);
        xfer(0, 3'd5, 1'b1, 32'd2);
        xfer_abort(2, 3'd2, $urandom, $urandom_range(1, 4), 1'b1);
        check_reset_outputs();
        for (int o = 0; o < 8; o++) xfer(2, 3'(o), 1'b0, 32'd0);
        xfer(2, 3'd6, 1'b1, $urandom);
        xfer(2, 3'd7, 1'b1, $urandom);
        xfer(2, 3'd6, 1'b0, 32'd0);
        xfer(0, 3'd0, 1'b0, 32'd0);

        // Random mix of transfers across all instances.
        for (int i = 0; i < 40; i++) begin
            int          k;
            logic [2:0]  off;
            logic        w;
            logic [31:0] d;
            k   = $urandom_range(0, 2);
            off = 3'($urandom_range(0, 7));
            w   = 1'($urandom_range(0, 1));
            d   = $urandom;
            if (off == 3'd5) d = $urandom_range(0, 7);
            xfer(k, off, w, d);
            idle($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
